// File: rtl/tank_pump_ctrl.sv
// rtl/tank_pump_ctrl.sv - probe debounce, thermometer level and fill-pump FSM with dry-run fault
// Optional fill counter output enabled by defining TANK_PUMP_STATS_EN.
module tank_pump_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LOW_LVL      = 1,
  parameter int HIGH_LVL     = 4,
  parameter int MAX_RUN_CYC  = 50000000,
  parameter int COOLDOWN_CYC = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] wet_i,
  input  logic       enable_i,
  input  logic       clear_i,
  output logic       pump_o,
  output logic       fault_o,
  output logic [2:0] level_o,
  output logic       incoh_o,
  output logic [1:0] state_o
`ifdef TANK_PUMP_STATS_EN
  ,
  output logic [15:0] fill_count_o
`endif
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int RUN_W = (MAX_RUN_CYC > 1) ? $clog2(MAX_RUN_CYC) : 1;
  localparam int CD_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYC - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    COOLDOWN = 2'd2,
    FAULT    = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [4:0]                 sync1_q, sync2_q;
  logic [4:0]                 stable_q, stable_d;
  logic [4:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [2:0]                 level_q, level_d, level_prev_q;
  logic                       incoh_q, incoh_d;
  logic                       run_ok;
  logic                       lvl_inc;
  logic [RUN_W-1:0]           run_cnt_q, run_cnt_d;
  logic [CD_W-1:0]            cd_cnt_q, cd_cnt_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // A wet probe seen after the first dry one breaks the thermometer code.
  always_comb begin
    level_d = 3'd0;
    incoh_d = 1'b0;
    run_ok  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (stable_q[i]) begin
        if (run_ok) level_d = level_d + 3'd1;
        else        incoh_d = 1'b1;
      end else begin
        run_ok = 1'b0;
      end
    end
  end

  assign lvl_inc = (level_q > level_prev_q);

  // A level rise on the terminal count clears the run counter, so it is not a timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable_i && !incoh_q && level_q <= 3'(LOW_LVL)) state_d = FILL;
      FILL: begin
        if (incoh_q || (run_cnt_q == RUN_LAST && !lvl_inc))  state_d = FAULT;
        else if (level_q >= 3'(HIGH_LVL) || !enable_i)       state_d = COOLDOWN;
      end
      COOLDOWN: if (cd_cnt_q == CD_LAST)                      state_d = IDLE;
      FAULT:    if (clear_i && !incoh_q)                      state_d = IDLE;
      default:                                                state_d = IDLE;
    endcase
  end

  assign run_cnt_d = (state_q == FILL && !lvl_inc) ? run_cnt_q + RUN_W'(1) : '0;
  assign cd_cnt_d  = (state_q == COOLDOWN) ? cd_cnt_q + CD_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      db_cnt_q     <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      incoh_q      <= 1'b0;
      run_cnt_q    <= '0;
      cd_cnt_q     <= '0;
      state_q      <= IDLE;
    end else begin
      sync1_q      <= wet_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      incoh_q      <= incoh_d;
      run_cnt_q    <= run_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      state_q      <= state_d;
    end
  end

  assign pump_o  = (state_q == FILL);
  assign fault_o = (state_q == FAULT);
  assign level_o = level_q;
  assign incoh_o = incoh_q;
  assign state_o = state_q;

`ifdef TANK_PUMP_STATS_EN
  logic [15:0] fill_cnt_q, fill_cnt_d;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (clear_i)
      fill_cnt_d = 16'd0;
    else if (state_q == IDLE && state_d == FILL && fill_cnt_q != 16'hFFFF)
      fill_cnt_d = fill_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_cnt_q <= 16'd0;
    else        fill_cnt_q <= fill_cnt_d;
  end

  assign fill_count_o = fill_cnt_q;
`endif

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// tb/tb_tank_pump_ctrl.sv - scoreboard bench for tank_pump_ctrl with a window-based reference model
// Stats checks are compiled in when TANK_PUMP_STATS_EN is defined.
module tb_tank_pump_ctrl;
  localparam int DEB = 4, LOW = 1, HIGH = 4, MAXR = 50, COOL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] wet_i = 5'd0;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       pump_o, fault_o, incoh_o;
  logic [2:0] level_o;
  logic [1:0] state_o;
`ifdef TANK_PUMP_STATS_EN
  logic [15:0] fill_count_o;
`endif

  always #5 clk = ~clk;

  tank_pump_ctrl #(
    .DEBOUNCE_CYC(DEB), .LOW_LVL(LOW), .HIGH_LVL(HIGH),
    .MAX_RUN_CYC(MAXR), .COOLDOWN_CYC(COOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wet_i(wet_i), .enable_i(enable_i), .clear_i(clear_i),
    .pump_o(pump_o), .fault_o(fault_o), .level_o(level_o), .incoh_o(incoh_o),
    .state_o(state_o)
`ifdef TANK_PUMP_STATS_EN
    , .fill_count_o(fill_count_o)
`endif
  );

  int n_chk = 0, n_pass = 0, cyc_cnt = 0;

  typedef struct { int cyc; logic [7:0] t; } exp_t;
  exp_t sb[$];

  int         m_state, m_level, m_prev, m_prog, m_cstart, m_fills;
  logic [4:0] m_stable;
  bit         m_incoh;
  logic [4:0] hist[$];
  logic [7:0] last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc_cnt);
  endtask

  function automatic logic [7:0] m_tuple();
    return {2'(m_state), 3'(m_level), m_incoh, m_state == 1, m_state == 3};
  endfunction

  task automatic push_exp();
    logic [7:0] t;
    t = m_tuple();
    if (t !== last_exp) begin
      sb.push_back('{cyc: cyc_cnt, t: t});
      last_exp = t;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_prev = 0; m_prog = 0; m_cstart = 0; m_fills = 0;
    m_stable = 5'd0; m_incoh = 1'b0;
    hist.delete();
    repeat (DEB + 2) hist.push_back(5'd0);
  endtask

  // One clock edge: a probe flips once the last DEB synchroniser outputs all disagree with it.
  task automatic model_step(input logic [4:0] w, input logic e, input logic c);
    logic [4:0] ns;
    int         nl;
    bit         ni, grew, flip;
    hist.push_back(w);
    ns = m_stable;
    for (int b = 0; b < 5; b++) begin
      flip = 1'b1;
      for (int d = 0; d < DEB; d++)
        if (hist[hist.size() - 3 - d][b] == m_stable[b]) flip = 1'b0;
      if (flip) ns[b] = ~m_stable[b];
    end
    void'(hist.pop_front());
    nl = 0;
    while (nl < 5 && m_stable[nl]) nl++;
    ni = (m_stable != 5'((1 << nl) - 1));
    grew = (m_level > m_prev);
    cyc_cnt++;
    case (m_state)
      0: if (e && !m_incoh && m_level <= LOW) begin
           m_state = 1; m_prog = cyc_cnt;
           if (m_fills < 65535) m_fills++;
         end
      1: if (m_incoh || (!grew && cyc_cnt - m_prog == MAXR)) m_state = 3;
         else if (m_level >= HIGH || !e) begin m_state = 2; m_cstart = cyc_cnt; end
         else if (grew) m_prog = cyc_cnt;
      2: if (cyc_cnt - m_cstart == COOL) m_state = 0;
      default: if (c && !m_incoh) m_state = 0;
    endcase
    if (c) m_fills = 0;
    m_stable = ns; m_prev = m_level; m_level = nl; m_incoh = ni;
    push_exp();
  endtask

  task automatic cyc(input logic [4:0] w, input logic e, input logic c);
    wet_i = w; enable_i = e; clear_i = c;
    @(posedge clk);
    model_step(w, e, c);
    #1;
  endtask

  task automatic hold(input logic [4:0] w, input logic e, input int n);
    repeat (n) cyc(w, e, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pump_async", pump_o, 1'b0);
    check("rst_outputs", {state_o, level_o, incoh_o, fault_o}, 7'd0);
    model_reset();
    push_exp();
    repeat (3) begin @(posedge clk); cyc_cnt++; end
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every change of the DUT's visible outputs must match the next expected change.
  initial begin
    logic [7:0] seen, cur;
    exp_t       e;
    seen = 8'h00;
    forever begin
      @(negedge clk);
      cur = {state_o, level_o, incoh_o, pump_o, fault_o};
      if (cur !== seen) begin
        if (sb.size() == 0) check("unexpected_change", cur, seen);
        else begin
          e = sb.pop_front();
          check("out_tuple", cur, e.t);
          check("change_cycle", cyc_cnt, e.cyc);
        end
        seen = cur;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        e = sb.pop_front();
        check("missed_change_cycle", cyc_cnt, e.cyc);
      end
    end
  end

  initial begin
    int lat, pumped, kind, len, l;
    logic [4:0] w;
    logic e;
    model_reset();
    last_exp = 8'h00;
    #12;
    check("reset_tuple", {state_o, level_o, incoh_o, pump_o, fault_o}, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Normal fill from level 3 down to 1, then climb to HIGH.
    hold(5'b00111, 1'b0, 20);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(5'b00001, 1'b1, 1'b0);
      if (lat == 0 && pump_o) lat = i;
    end
    check("fill_latency", lat, 8);
    hold(5'b00011, 1'b1, 20);
    hold(5'b00111, 1'b1, 20);
    hold(5'b01111, 1'b1, 8);
    check("high_cooldown", {state_o, pump_o}, {2'd2, 1'b0});
    hold(5'b01111, 1'b1, 10);
    check("cooldown_end", state_o, 2'd0);

    // Glitch rejection at level 3.
    hold(5'b00111, 1'b1, 20);
    hold(5'b00011, 1'b1, 3);
    hold(5'b00111, 1'b1, 15);
    check("glitch_level", {state_o, level_o}, {2'd0, 3'd3});

    // Dry-run timeout.
    pumped = 0;
    for (int i = 0; i < 150 && state_o != 2'd3; i++) begin
      cyc(5'b00000, 1'b1, 1'b0);
      if (pump_o) pumped++;
    end
    check("dry_fault", {state_o, fault_o, pump_o}, {2'd3, 1'b1, 1'b0});
    check("dry_fill_cycles", pumped, MAXR);
    cyc(5'b00000, 1'b0, 1'b1);
    cyc(5'b00000, 1'b0, 1'b0);
    check("dry_clear", state_o, 2'd0);

    // Incoherent probes during FILL.
    hold(5'b00000, 1'b1, 3);
    hold(5'b00101, 1'b1, 10);
    check("incoh_fault", {state_o, incoh_o}, {2'd3, 1'b1});
    cyc(5'b00101, 1'b1, 1'b1);
    hold(5'b00101, 1'b1, 2);
    check("incoh_clear_ignored", state_o, 2'd3);
    hold(5'b00011, 1'b0, 10);
    cyc(5'b00011, 1'b0, 1'b1);
    check("incoh_clear_ok", {state_o, incoh_o}, {2'd0, 1'b0});

    // Disable mid-FILL, then reset mid-FILL.
    hold(5'b00000, 1'b1, 15);
    check("disable_pre", state_o, 2'd1);
    cyc(5'b00000, 1'b0, 1'b0);
    check("disable_cooldown", state_o, 2'd2);
    hold(5'b00000, 1'b0, 12);
    hold(5'b00000, 1'b1, 5);
    do_reset();

    // Randomised segments: mostly thermometer patterns, some arbitrary, short holds act as glitches.
    for (int s = 0; s < 90; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 25);
      if (kind < 7) begin
        l = $urandom_range(0, 5);
        w = 5'((1 << l) - 1);
      end else begin
        w = 5'($urandom);
      end
      e = ($urandom_range(0, 4) != 0);
      cyc(w, e, $urandom_range(0, 7) == 0);
      hold(w, e, len - 1);
    end
    hold(5'b11111, 1'b0, 30);
    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);

`ifdef TANK_PUMP_STATS_EN
    model_reset();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      hold(5'b00000, 1'b1, 15);
      hold(5'b01111, 1'b1, 25);
    end
    check("stats_three", fill_count_o, 16'(m_fills));
    check("stats_three_abs", fill_count_o, 16'd3);
    cyc(5'b01111, 1'b0, 1'b1);
    check("stats_clear", fill_count_o, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tank_pump_ctrl.md
Name: tank_pump_ctrl

Overview:
- Downstream consumer of the five inverted moisture-sensor outputs, led0..led4, which are active-high "wet" signals with bit0 as the lowest probe.
- Synchronises and debounces each probe, then derives a thermometer water level.
- Drives the fill pump with hysteresis, a dry-run timeout fault and a post-fill cooldown.
- Sits between the sensor inversion stage and the pump relay / status LEDs.

Parameters:
- DEBOUNCE_CYC, 500000: cycles a synced probe must hold a new value before it is accepted (min 2).
- LOW_LVL, 1: start filling when level <= LOW_LVL (range 0..4).
- HIGH_LVL, 4: stop filling when level >= HIGH_LVL (range LOW_LVL+1..5).
- MAX_RUN_CYC, 50000000: fill cycles allowed without a level increase before FAULT.
- COOLDOWN_CYC, 5000000: pump-off hold time after a fill ends.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- wet_i, in, 5: probe wet flags, bit n = led n, asynchronous to clk.
- enable_i, in, 1: pump operation permitted.
- clear_i, in, 1: synchronous fault-clear pulse.
- pump_o, out, 1: pump drive, 1 = on.
- fault_o, out, 1: latched fault indicator.
- level_o, out, 3: debounced water level, 0..5.
- incoh_o, out, 1: debounced probe pattern is non-thermometer.
- state_o, out, 2: 0 IDLE, 1 FILL, 2 COOLDOWN, 3 FAULT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Sync flops, debounced bits and all counters clear to 0.
  - FSM goes to IDLE.
  - pump_o=0, fault_o=0, level_o=0, incoh_o=0, state_o=0.
- Synchronisation: two-flop synchroniser per wet_i bit.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE_CYC):
  - When synced == stable: counter <= 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 while the bits still differ: stable <= synced and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYC synced cycles is never accepted.
- Level: count of consecutive wet stable bits starting at bit0.
  - Registered, updated one cycle after the stable bits change.
- incoh_o is registered and set when any wet stable bit lies above a dry bit (e.g. 5'b00101).
- Pump latency:
  - Clean input edge to stable bit: 2 + DEBOUNCE_CYC cycles.
  - Plus 1 cycle to level_o.
  - Plus 1 cycle to state_o / pump_o.
- pump_o = (state == FILL), registered. fault_o = (state == FAULT).
- FSM transitions, evaluated each clk in this priority order:
  - IDLE -> FILL: enable_i && !incoh && level <= LOW_LVL.
  - FILL -> FAULT: incoh, or run counter == MAX_RUN_CYC-1.
  - FILL -> COOLDOWN: level >= HIGH_LVL, or enable_i == 0.
  - COOLDOWN -> IDLE: cooldown counter == COOLDOWN_CYC-1. enable_i is ignored in this state.
  - FAULT -> IDLE: clear_i == 1 && !incoh. Otherwise the FSM stays in FAULT with the pump off.
- Run counter:
  - Clears on entry to FILL and on every cycle in which level_o increases.
  - Increments otherwise while in FILL.
  - Never wraps, because FAULT is taken at the terminal count.
- Simultaneous events in FILL:
  - FAULT beats COOLDOWN.
  - Reaching HIGH_LVL on the same cycle as the timeout goes to COOLDOWN, because the level increase clears the run counter first.
- Level drop during FILL (sensor noise) does not stop the pump; the run counter keeps counting.
- Reset asserted mid-FILL: pump_o drops asynchronously to 0.

Optional Feature:
- Macro: TANK_PUMP_STATS_EN.
- When defined:
  - Adds output fill_count_o, 16 bits.
  - Increments on each IDLE->FILL transition and saturates at 16'hFFFF.
  - Resets to 0 on rst_n and also clears on clear_i.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYC=4, LOW_LVL=1, HIGH_LVL=4, MAX_RUN_CYC=50, COOLDOWN_CYC=10):
- Normal fill:
  - Stimulus: enable_i=1, wet_i=5'b00001 held.
  - Response: level_o=1, then pump_o=1 exactly 8 cycles after the edge.
  - Then step wet_i to 00011, 00111, 01111 at 20-cycle intervals: pump_o=0 and state_o=2 eight cycles after 01111; state_o=0 ten cycles later.
- Glitch rejection:
  - Stimulus: in IDLE with level 3, pulse wet_i bit2 low for 3 cycles.
  - Response: level_o stays 3 and the FSM does not change.
- Dry-run timeout:
  - Stimulus: start a fill at level 0, hold wet_i=0.
  - Response: state_o=3, fault_o=1, pump_o=0 after 50 FILL cycles.
  - Then clear_i pulse: state_o returns to IDLE.
- Incoherent probes:
  - Stimulus: during FILL apply wet_i=5'b00101.
  - Response: incoh_o=1, then FAULT.
  - clear_i is ignored while 00101 is held; it is accepted after wet_i=00011.
- Disable and reset:
  - Stimulus: deassert enable_i mid-FILL.
  - Response: COOLDOWN next cycle.
  - Then assert rst_n=0 mid-FILL: pump_o=0 immediately and all outputs return to reset values.
- Stats (with TANK_PUMP_STATS_EN):
  - Stimulus: three complete fills.
  - Response: fill_count_o=3; clear_i returns it to 0.
